// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide synchronous RAM port between the
// instruction-fetch stage and the load/store stage. Each access is sequenced
// one byte per cycle and returned as a little-endian 32-bit word.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [1:0]        mem_sel,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic              owner_mem;   // 1 = access belongs to MEM, 0 = IF
    logic              is_write;
    logic [2:0]        count;       // bytes in this access: 1, 2 or 4
    logic [2:0]        k;           // current byte index
    logic [2:0]        k_next;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       wbuf;
    logic [31:0]       rbuf;
    logic [31:0]       assembled;

    // Address bits above the RAM width are dropped; the RAM wraps silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    function automatic logic [2:0] byte_count(input logic [1:0] sel);
        case (sel)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

    assign k_next    = k + 3'd1;
    assign next_addr = base + ADDR_W'(k_next);

    // Merge the byte returned for the previous address into its lane.
    always_comb begin
        assembled = rbuf;
        case (k)
            3'd1:    assembled[7:0]   = ram_rdata;
            3'd2:    assembled[15:8]  = ram_rdata;
            3'd3:    assembled[23:16] = ram_rdata;
            3'd4:    assembled[31:24] = ram_rdata;
            default: ;
        endcase
    end

    // Arbitration, byte sequencing and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= 3'd0;
            owner_mem <= 1'b0;
            is_write  <= 1'b0;
            count     <= 3'd0;
            base      <= '0;
            wbuf      <= '0;
            rbuf      <= '0;
            if_data   <= '0;
            mem_rdata <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            ram_we    <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            ram_we   <= 1'b0;
            case (state)
                IDLE: begin
                    // MEM holds the older instruction, so it always wins.
                    if (mem_req) begin
                        owner_mem <= 1'b1;
                        is_write  <= mem_we;
                        count     <= byte_count(mem_sel);
                        base      <= mem_addr[ADDR_W-1:0];
                        wbuf      <= mem_wdata;
                        rbuf      <= '0;
                        k         <= 3'd0;
                        state     <= XFER;
                        ram_addr  <= mem_addr[ADDR_W-1:0];
                        ram_we    <= mem_we;
                        ram_wdata <= mem_wdata[7:0];
                    end else if (if_req && !if_flush) begin
                        owner_mem <= 1'b0;
                        is_write  <= 1'b0;
                        count     <= 3'd4;
                        base      <= if_addr[ADDR_W-1:0];
                        rbuf      <= '0;
                        k         <= 3'd0;
                        state     <= XFER;
                        ram_addr  <= if_addr[ADDR_W-1:0];
                    end
                end
                XFER: begin
                    if (!owner_mem && if_flush) begin
                        // Abandon the fetch; if_data keeps its previous word.
                        state <= IDLE;
                        k     <= 3'd0;
                    end else if (is_write) begin
                        if (k_next < count) begin
                            k         <= k_next;
                            ram_we    <= 1'b1;
                            ram_addr  <= next_addr;
                            ram_wdata <= byte_lane(wbuf, k_next[1:0]);
                        end else begin
                            state    <= DONE;
                            k        <= 3'd0;
                            mem_done <= 1'b1;
                        end
                    end else begin
                        // Reads run one cycle behind the address stream.
                        if (k != 3'd0) begin
                            rbuf <= assembled;
                        end
                        if (k == count) begin
                            state <= DONE;
                            k     <= 3'd0;
                            if (owner_mem) begin
                                mem_rdata <= assembled;
                                mem_done  <= 1'b1;
                            end else begin
                                if_data <= assembled;
                                if_done <= 1'b1;
                            end
                        end else begin
                            k <= k_next;
                            if (k_next < count) begin
                                ram_addr <= next_addr;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    k     <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector table, hand-written multi-cycle sequences and
// randomized accesses compared against a transaction-level memory model.
module tb_mem_ctrl;

    localparam int AW    = 17;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_flush;
    logic [31:0]   if_data;
    logic          if_done;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [1:0]    mem_sel;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_done;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata = '0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram     [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    bit         loaded = 1'b0;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_sel   (mem_sel),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            'h00000: return 8'h12;
            'h00001: return 8'h05;
            'h00002: return 8'h00;
            'h00003: return 8'h00;
            'h00010: return 8'hA0;
            'h00011: return 8'hA1;
            'h00012: return 8'hEE;
            'h00013: return 8'hFF;
            'h00040: return 8'hEF;
            'h00041: return 8'hBE;
            'h00042: return 8'hAD;
            'h00043: return 8'hDE;
            'h00100: return 8'h13;
            'h00101: return 8'h05;
            'h00102: return 8'h00;
            'h00103: return 8'h00;
            'h00200: return 8'hB7;
            'h00201: return 8'h12;
            'h00202: return 8'h34;
            'h00203: return 8'h56;
            'h00300: return 8'h00;
            'h00301: return 8'h00;
            'h00302: return 8'h00;
            'h00303: return 8'h00;
            'h02000: return 8'h11;
            'h02001: return 8'h55;
            'h02002: return 8'h77;
            'h02003: return 8'h00;
            'h1FFFF: return 8'h34;
            default: return 8'(a * 7 + 3);
        endcase
    endfunction

    // Synchronous byte RAM: read data one cycle after the address.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_byte(i);
            loaded <= 1'b1;
        end else begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    // Transaction-level model: byte-wise access with wrap, zero-extended read,
    // done after N+2 cycles for reads and N+1 for writes.
    function automatic void model_access(input bit is_if, input bit we, input logic [31:0] addr,
                                         input logic [1:0] sel, input logic [31:0] wdata,
                                         output logic [31:0] data, output int lat);
        int n;
        int a;
        n = is_if ? 4 : (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
        data = 32'h0;
        for (int b = 0; b < n; b++) begin
            a = int'((addr + 32'(b)) & 32'(DEPTH - 1));
            if (we) ref_mem[a] = 8'(wdata >> (8 * b));
            else    data = data | (32'(ref_mem[a]) << (8 * b));
        end
        lat = we ? n + 1 : n + 2;
    endfunction

    // Issue one access, watch the RAM port each cycle, return data and latency.
    task automatic run_access(input bit is_if, input bit we, input logic [31:0] addr,
                              input logic [1:0] sel, input logic [31:0] wdata,
                              output logic [31:0] got, output int lat);
        int n;
        logic [AW-1:0] ea;
        logic done_now;
        n = is_if ? 4 : (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
        @(posedge clk); #1;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_addr  = addr;
            mem_sel   = sel;
            mem_wdata = wdata;
        end
        lat = -1;
        got = 32'hx;
        for (int i = 1; i <= 12 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (i <= n) begin
                ea = AW'(addr + 32'(i - 1));
                check("ram_addr", 32'(ram_addr), 32'(ea));
                check("ram_we", 32'(ram_we), 32'(we));
                if (we) check("ram_wdata", 32'(ram_wdata), 32'(8'(wdata >> (8 * (i - 1)))));
            end else begin
                check("ram_we_idle", 32'(ram_we), 32'h0);
            end
            check("other_done", 32'(is_if ? mem_done : if_done), 32'h0);
            done_now = is_if ? if_done : mem_done;
            if (done_now) begin
                lat     = i;
                got     = is_if ? if_data : mem_rdata;
                if_req  = 1'b0;
                mem_req = 1'b0;
                mem_we  = 1'b0;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL access_timeout: got no done required done within 12 cycles");
            if_req  = 1'b0;
            mem_req = 1'b0;
        end
    endtask

    typedef struct {
        bit          is_if;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  sel;
        logic [31:0] wdata;
        bit          chk_data;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] mdl;
        int          lat;
        int          mlat;
        int          md;
        int          id;
        logic [31:0] mdata;
        logic [31:0] idata;
        bit          saw_done;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 2'd2, 32'h0,         1'b1, 32'h0000_0513, 6};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2001, 2'd0, 32'h1234_56AB, 1'b0, 32'h0,         2};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_2000, 2'd2, 32'h0,         1'b1, 32'h0077_AB11, 6};
        vecs[3] = '{1'b0, 1'b0, 32'h0001_FFFF, 2'd1, 32'h0,         1'b1, 32'h0000_1234, 4};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0040, 2'd3, 32'h0,         1'b1, 32'hDEAD_BEEF, 6};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0300, 2'd1, 32'hCAFE_BABE, 1'b0, 32'h0,         3};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0300, 2'd2, 32'h0,         1'b1, 32'h0000_BABE, 6};
        vecs[7] = '{1'b0, 1'b0, 32'hABC2_0040, 2'd0, 32'h0,         1'b1, 32'h0000_00EF, 3};
        vecs[8] = '{1'b0, 1'b1, 32'h0001_FFFE, 2'd2, 32'hA1B2_C3D4, 1'b0, 32'h0,         5};
        vecs[9] = '{1'b1, 1'b0, 32'h0001_FFFE, 2'd2, 32'h0,         1'b1, 32'hA1B2_C3D4, 6};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);

        rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_if_data", if_data, 32'h0);
        check("reset_mem_rdata", mem_rdata, 32'h0);
        check("reset_ram_port", {ram_addr, ram_wdata, ram_we}, 32'h0);
        check("reset_dones", {if_done, mem_done}, 32'h0);
        rst = 1'b1;

        // Contention: MEM load and IF fetch raised together.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; mem_sel = 2'd2;
        md = -1; id = -1; mdata = '0; idata = '0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (mem_done && md < 0) begin md = i; mdata = mem_rdata; mem_req = 1'b0; end
            if (if_done && id < 0) begin id = i; idata = if_data; if_req = 1'b0; end
        end
        if_req = 1'b0; mem_req = 1'b0;
        check("contend_mem_done_cycle", 32'(md), 32'd6);
        check("contend_mem_rdata", mdata, 32'hDEAD_BEEF);
        check("contend_if_done_cycle", 32'(id), 32'd13);
        check("contend_if_data", idata, 32'h0000_0512);

        // Flush mid-fetch, then a new fetch starts in the following IDLE cycle.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) begin @(posedge clk); #1; end
        if_flush = 1'b1;
        check("flush_no_done_t3", 32'(if_done), 32'h0);
        @(posedge clk); #1;
        if_flush = 1'b0; if_addr = 32'h200;
        check("flush_no_done_t4", 32'(if_done), 32'h0);
        id = -1; idata = '0;
        for (int i = 5; i <= 14; i++) begin
            @(posedge clk); #1;
            if (i == 5) check("flush_refetch_addr", 32'(ram_addr), 32'h200);
            if (if_done && id < 0) begin id = i; idata = if_data; if_req = 1'b0; end
        end
        if_req = 1'b0;
        check("flush_refetch_done_cycle", 32'(id), 32'd10);
        check("flush_refetch_data", idata, 32'h5634_12B7);

        // Directed vector table.
        for (int v = 0; v < 10; v++) begin
            run_access(vecs[v].is_if, vecs[v].we, vecs[v].addr, vecs[v].sel, vecs[v].wdata, got, lat);
            model_access(vecs[v].is_if, vecs[v].we, vecs[v].addr, vecs[v].sel, vecs[v].wdata, mdl, mlat);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            if (vecs[v].chk_data) check($sformatf("vec%0d_data", v), got, vecs[v].exp_data);
        end

        // Reset in the middle of a word store.
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_sel = 2'd2; mem_wdata = 32'h1122_3344;
        saw_done = 1'b0;
        repeat (2) begin @(posedge clk); #1; saw_done |= mem_done; end
        rst = 1'b0;
        @(posedge clk); #1;
        mem_req = 1'b0; mem_we = 1'b0;
        check("rstmid_if_data", if_data, 32'h0);
        check("rstmid_mem_rdata", mem_rdata, 32'h0);
        check("rstmid_ram_port", {ram_addr, ram_wdata, ram_we}, 32'h0);
        check("rstmid_dones", {if_done, mem_done}, 32'h0);
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; saw_done |= mem_done; end
        check("rstmid_no_mem_done", 32'(saw_done), 32'h0);
        check("rstmid_ram_bytes", {ram[16], ram[17], ram[18], ram[19]}, 32'h4433_EEFF);
        ref_mem[16] = 8'h44;
        ref_mem[17] = 8'h33;

        // Randomized accesses against the model.
        for (int t = 0; t < 60; t++) begin
            bit          r_if;
            bit          r_we;
            logic [1:0]  r_sel;
            logic [31:0] r_addr;
            logic [31:0] r_wd;
            r_if  = ($urandom_range(0, 2) == 0);
            r_we  = !r_if && ($urandom_range(0, 1) == 1);
            r_sel = 2'($urandom_range(0, 3));
            r_wd  = $urandom();
            if ($urandom_range(0, 3) == 0) r_addr = 32'h0001_FFFC + 32'($urandom_range(0, 3));
            else                           r_addr = 32'h0001_0000 + 32'($urandom_range(0, 63));
            r_addr[31:AW] = (32 - AW)'($urandom());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_access(r_if, r_we, r_addr, r_sel, r_wd, got, lat);
            model_access(r_if, r_we, r_addr, r_sel, r_wd, mdl, mlat);
            check($sformatf("rand%0d_latency", t), 32'(lat), 32'(mlat));
            if (!r_we) check($sformatf("rand%0d_data", t), got, mdl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
